conv_result_collector: RTL and testbench

CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

---
 rtl/conv_result_collector_if.sv | 29 ++
 rtl/conv_result_collector.sv | 122 ++++++++++++
 tb/tb_conv_result_collector.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_collector_if.sv
// Bundle of the collector's control, result-stream, host-read and status signals.
// master = engine/host side driving the collector, slave = the collector itself.
interface conv_result_collector_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic              in_done;
  logic [31:0]       in_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              busy;
  logic              frame_done;
  logic              short_frame;
  logic              overflow;
  logic [ADDR_W:0]   count;
  logic [31:0]       max_val;

  modport master (
    output start, in_valid, in_done, in_data, rd_en, rd_addr,
    input  rd_data, busy, frame_done, short_frame, overflow, count, max_val
  );

  modport slave (
    input  start, in_valid, in_done, in_data, rd_en, rd_addr,
    output rd_data, busy, frame_done, short_frame, overflow, count, max_val
  );
endinterface

// File: rtl/conv_result_collector.sv
// Captures one frame of convolution results into a row-major buffer, tracking
// count, running signed maximum and short-frame/overflow status; host reads are read-first.
module conv_result_collector #(
  parameter int OUT_ROWS = 6,
  parameter int OUT_COLS = 6,
  parameter int RELU     = 1,
  parameter int ADDR_W   = 6
) (
  input logic                    clk,
  input logic                    reset,
  conv_result_collector_if.slave bus
);
  localparam int              TOTAL   = OUT_ROWS * OUT_COLS;
  localparam logic [ADDR_W:0] TOTAL_W = TOTAL[ADDR_W:0];
  localparam logic [31:0]     MAX_RST = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic signed [31:0] max_q, max_d;
  logic               short_q, short_d;
  logic               ovf_q, ovf_d;
  logic               fd_q, fd_d;
  logic [31:0]        rd_data_q;
  logic               we;
  logic signed [31:0] stored;
  logic [31:0]        mem [2**ADDR_W];

  assign stored = (RELU != 0 && bus.in_data[31]) ? '0 : bus.in_data;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    short_d = short_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CAPTURE;
          count_d = '0;
          max_d   = MAX_RST;
          short_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      CAPTURE: begin
        if (bus.start) begin
          count_d = '0;
          max_d   = MAX_RST;
          short_d = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          if (bus.in_valid) begin
            we      = 1'b1;
            count_d = count_q + (ADDR_W + 1)'(1);
            if (stored > max_q) max_d = stored;
          end
          // Completion is judged on the count after this cycle's write.
          if (count_d == TOTAL_W) begin
            state_d = DONE;
          end else if (bus.in_done) begin
            state_d = DONE;
            short_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          state_d = CAPTURE;
          count_d = '0;
          max_d   = MAX_RST;
          short_d = 1'b0;
          ovf_d   = 1'b0;
        end else if (bus.in_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    fd_d = (state_d == DONE) && (state_q != DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      max_q     <= MAX_RST;
      short_q   <= 1'b0;
      ovf_q     <= 1'b0;
      fd_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      max_q   <= max_d;
      short_q <= short_d;
      ovf_q   <= ovf_d;
      fd_q    <= fd_d;
      if (bus.rd_en) begin
        rd_data_q <= ({1'b0, bus.rd_addr} < TOTAL_W) ? mem[bus.rd_addr] : '0;
      end
    end
  end

  // NOTE: the buffer is deliberately not reset; only its write is gated by reset.
  always_ff @(posedge clk) begin
    if (reset && we) mem[count_q[ADDR_W-1:0]] <= stored;
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = (state_q == CAPTURE);
  assign bus.frame_done  = fd_q;
  assign bus.short_frame = short_q;
  assign bus.overflow    = ovf_q;
  assign bus.count       = count_q;
  assign bus.max_val     = max_q;
endmodule

// File: tb/tb_conv_result_collector.sv
// Scoreboard bench for conv_result_collector: a small frame model predicts count, max and
// buffer contents; expected read data is queued when a read is issued and compared a cycle later.
module tb_conv_result_collector;
  localparam int ADDR_W = 6;
  localparam int TOTAL  = 36;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_result_collector_if #(.ADDR_W(ADDR_W)) bus ();

  conv_result_collector #(
    .OUT_ROWS(6), .OUT_COLS(6), .RELU(1), .ADDR_W(ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          fd_seen = 0;
  logic [31:0] rd_q [$];
  logic [31:0] m_mem [64];
  int          m_cnt;
  logic signed [31:0] m_max;
  bit          m_cap;

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    m_cnt = 0; m_max = 32'sh8000_0000; m_cap = 1'b1;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_count", 32'(bus.count), 32'd0);
  endtask

  // One sample (optionally with in_done); the model only captures while a frame is open.
  task automatic send(input logic signed [31:0] v, input bit done);
    logic signed [31:0] st;
    bus.in_valid = 1'b1; bus.in_data = v; bus.in_done = done;
    if (m_cap) begin
      st = (v < 0) ? 32'sd0 : v;
      m_mem[m_cnt] = st;
      m_cnt++;
      if (st > m_max) m_max = st;
      if (m_cnt == TOTAL || done) m_cap = 1'b0;
    end
    step();
    bus.in_valid = 1'b0; bus.in_done = 1'b0;
    check("count", 32'(bus.count), 32'(m_cnt));
    check("max_val", bus.max_val, m_max);
  endtask

  task automatic end_frame();
    bus.in_done = 1'b1;
    step();
    bus.in_done = 1'b0;
    m_cap = 1'b0;
  endtask

  task automatic issue_rd(input int addr);
    bus.rd_en = 1'b1;
    bus.rd_addr = addr[ADDR_W-1:0];
    rd_q.push_back((addr < TOTAL) ? m_mem[addr] : 32'd0);
  endtask

  task automatic rd(input int addr);
    issue_rd(addr);
    step();
    bus.rd_en = 1'b0;
    check("rd_data", bus.rd_data, rd_q.pop_front());
  endtask

  initial begin
    int fd0;
    reset = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_done = 1'b0; bus.in_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    m_cnt = 0; m_max = 32'sh8000_0000; m_cap = 1'b0;
    step(); step();
    reset = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_fd", 32'(bus.frame_done), 32'd0);
    check("rst_short", 32'(bus.short_frame), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_max", bus.max_val, 32'h8000_0000);

    // IDLE ignores the stream and in_done
    send(32'sd5, 1'b1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_short", 32'(bus.short_frame), 32'd0);

    // Full frame of k-18
    start_frame();
    fd0 = fd_seen;
    for (int k = 0; k < TOTAL; k++) begin
      send(32'(k - 18), 1'b0);
      if (k < TOTAL - 1) check("fd_early", 32'(bus.frame_done), 32'd0);
    end
    check("full_fd", 32'(bus.frame_done), 32'd1);
    check("full_busy", 32'(bus.busy), 32'd0);
    step();
    check("full_fd_once", 32'(fd_seen - fd0), 32'd1);
    check("full_short", 32'(bus.short_frame), 32'd0);
    check("full_max", bus.max_val, 32'd17);
    rd(0); rd(18); rd(19); rd(35); rd(40);

    // Overflow after a full frame
    send(32'sd500, 1'b0);
    send(32'sd600, 1'b0);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_fd", 32'(fd_seen - fd0), 32'd1);
    rd(35);

    // Short frame of six samples ending on in_done alone
    start_frame();
    check("start_clr_ovf", 32'(bus.overflow), 32'd0);
    fd0 = fd_seen;
    for (int k = 0; k < 5; k++) send(32'sd0, 1'b0);
    send(32'sd3, 1'b0);
    end_frame();
    step();
    check("short6_flag", 32'(bus.short_frame), 32'd1);
    check("short6_count", 32'(bus.count), 32'd6);
    check("short6_fd", 32'(fd_seen - fd0), 32'd1);

    // Read-first on mem[5] (holds 3) while 7 is written there, then the simultaneous end
    start_frame();
    check("start_clr_short", 32'(bus.short_frame), 32'd0);
    fd0 = fd_seen;
    for (int k = 0; k < 5; k++) send(32'sd0, 1'b0);
    issue_rd(5);
    send(32'sd7, 1'b0);
    bus.rd_en = 1'b0;
    check("rd_first", bus.rd_data, rd_q.pop_front());
    rd(5); rd(40);
    for (int k = 0; k < 29; k++) send(32'(k), 1'b0);
    send(32'sd100, 1'b1);
    step();
    check("simul_short", 32'(bus.short_frame), 32'd0);
    check("simul_fd", 32'(fd_seen - fd0), 32'd1);
    rd(35);

    // Ten-sample short frame
    start_frame();
    fd0 = fd_seen;
    for (int k = 0; k < 10; k++) send(32'(1000 + k), 1'b0);
    end_frame();
    check("short10_busy", 32'(bus.busy), 32'd0);
    step(); step();
    check("short10_flag", 32'(bus.short_frame), 32'd1);
    check("short10_count", 32'(bus.count), 32'd10);
    check("short10_fd", 32'(fd_seen - fd0), 32'd1);

    // start during CAPTURE restarts and discards the same-cycle sample
    start_frame();
    send(-32'sd1, 1'b0); send(32'sd2, 1'b0); send(32'sd3, 1'b0);
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 32'd55;
    step();
    bus.start = 1'b0; bus.in_valid = 1'b0;
    m_cnt = 0; m_max = 32'sh8000_0000;
    check("restart_count", 32'(bus.count), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_max", bus.max_val, 32'h8000_0000);
    send(32'sd9, 1'b0);
    rd(0);

    // Reset mid-frame after 20 samples
    for (int k = 1; k < 20; k++) send(32'(k * 3), 1'b0);
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.start = 1'b1; bus.rd_en = 1'b1; bus.rd_addr = 6'd0;
    step();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.rd_en = 1'b0;
    m_cnt = 0; m_max = 32'sh8000_0000; m_cap = 1'b0;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_count", 32'(bus.count), 32'd0);
    check("mrst_max", bus.max_val, 32'h8000_0000);
    check("mrst_rd_data", bus.rd_data, 32'd0);
    for (int k = 0; k < 3; k++) send(32'sd77, 1'b0);
    check("mrst_idle_busy", 32'(bus.busy), 32'd0);
    rd(0); rd(19);

    if (rd_q.size() != 0) check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
